// File: rtl/gb_lcd_capture.sv
// Game Boy DMG LCD bus capture into a 160x144x2-bit framebuffer.
// Synchronises the async GB bus, writes pixels and checks frame geometry.
module gb_lcd_capture #(
  parameter int H_PIXELS   = 160,
  parameter int V_PIXELS   = 144,
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 2,
  parameter int INVERT     = 1
) (
  input  logic                  CLK100MHz,
  input  logic                  reset_n,
  input  logic                  gb_pclk,
  input  logic                  gb_hsync,
  input  logic                  gb_vsync,
  input  logic [DATA_WIDTH-1:0] gb_data,
  output logic [ADDR_WIDTH-1:0] fb_waddr,
  output logic [DATA_WIDTH-1:0] fb_din,
  output logic                  fb_we,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic                  capturing
);

  localparam logic [7:0] H_LIM = 8'(H_PIXELS);
  localparam logic [7:0] V_LIM = 8'(V_PIXELS);
  localparam logic [8:0] V_CNT = 9'(V_PIXELS);

  typedef enum logic {
    WAIT_VSYNC = 1'b0,
    ACTIVE     = 1'b1
  } state_t;

  state_t state, state_n;

  logic [2:0] pclk_s, hs_s, vs_s;
  logic [DATA_WIDTH-1:0] data_s1, data_s2;

  logic pclk_fall, hs_rise, vs_rise;

  logic [7:0] col, row, col_n, row_n, col_p;
  logic [ADDR_WIDTH-1:0] line_base, base_n, waddr_n;
  logic [DATA_WIDTH-1:0] din_n;
  logic len_err, err_n, err_p;
  logic we_n, done_n, ok_n;
  logic [8:0] lines;

  // bit 0 is s1, bit 1 is s2, bit 2 is s3
  always_ff @(posedge CLK100MHz) begin
    if (!reset_n) begin
      pclk_s  <= '0;
      hs_s    <= '0;
      vs_s    <= '0;
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      pclk_s  <= {pclk_s[1:0], gb_pclk};
      hs_s    <= {hs_s[1:0], gb_hsync};
      vs_s    <= {vs_s[1:0], gb_vsync};
      data_s1 <= gb_data;
      data_s2 <= data_s1;
    end
  end

  assign pclk_fall = pclk_s[2] & ~pclk_s[1];
  assign hs_rise   = ~hs_s[2] & hs_s[1];
  assign vs_rise   = ~vs_s[2] & vs_s[1];

  always_ff @(posedge CLK100MHz) begin
    if (!reset_n) state <= WAIT_VSYNC;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state == WAIT_VSYNC && vs_rise) state_n = ACTIVE;
  end

  always_comb begin
    col_n   = col;
    row_n   = row;
    base_n  = line_base;
    err_n   = len_err;
    we_n    = 1'b0;
    waddr_n = fb_waddr;
    din_n   = fb_din;
    done_n  = 1'b0;
    ok_n    = frame_ok;
    col_p   = col;
    err_p   = len_err;
    lines   = '0;
    if (state == ACTIVE) begin
      // the pixel is always applied before any line or frame action
      if (pclk_fall) begin
        if (col < H_LIM) begin
          col_p = col + 8'd1;
          if (row < V_LIM) begin
            we_n    = 1'b1;
            waddr_n = line_base + ADDR_WIDTH'(col);
            din_n   = (INVERT != 0) ? ~data_s2 : data_s2;
          end
        end else begin
          err_p = 1'b1;
        end
      end
      if (vs_rise) begin
        lines  = {1'b0, row} + {8'd0, col_p != 8'd0};
        done_n = 1'b1;
        ok_n   = (lines == V_CNT) && !err_p &&
                 !(col_p != 8'd0 && col_p != H_LIM);
        col_n  = '0;
        row_n  = '0;
        base_n = '0;
        err_n  = 1'b0;
      end else if (hs_rise && col_p != 8'd0) begin
        err_n = err_p | (col_p != H_LIM);
        col_n = '0;
        if (row < V_LIM) begin
          row_n  = row + 8'd1;
          base_n = line_base + ADDR_WIDTH'(H_PIXELS);
        end
      end else begin
        col_n = col_p;
        err_n = err_p;
      end
    end else if (vs_rise) begin
      col_n  = '0;
      row_n  = '0;
      base_n = '0;
      err_n  = 1'b0;
    end
  end

  always_ff @(posedge CLK100MHz) begin
    if (!reset_n) begin
      col        <= '0;
      row        <= '0;
      line_base  <= '0;
      len_err    <= 1'b0;
      fb_we      <= 1'b0;
      fb_waddr   <= '0;
      fb_din     <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
    end else begin
      col        <= col_n;
      row        <= row_n;
      line_base  <= base_n;
      len_err    <= err_n;
      fb_we      <= we_n;
      fb_waddr   <= waddr_n;
      fb_din     <= din_n;
      frame_done <= done_n;
      frame_ok   <= ok_n;
    end
  end

  assign capturing = (state == ACTIVE);

endmodule

// File: tb/tb_gb_lcd_capture.sv
// Randomised scoreboard bench for gb_lcd_capture.
// A frame-level model predicts writes and frame health.
module tb_gb_lcd_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        gb_pclk;
  logic        gb_hsync;
  logic        gb_vsync;
  logic [1:0]  gb_data;
  logic [14:0] fb_waddr;
  logic [1:0]  fb_din;
  logic        fb_we;
  logic        frame_done;
  logic        frame_ok;
  logic        capturing;

  gb_lcd_capture dut (
    .CLK100MHz (clk),
    .reset_n   (reset_n),
    .gb_pclk   (gb_pclk),
    .gb_hsync  (gb_hsync),
    .gb_vsync  (gb_vsync),
    .gb_data   (gb_data),
    .fb_waddr  (fb_waddr),
    .fb_din    (fb_din),
    .fb_we     (fb_we),
    .frame_done(frame_done),
    .frame_ok  (frame_ok),
    .capturing (capturing)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_wr[$];
  bit  exp_ok[$];
  wr_t mon_w;
  bit  mon_ok;
  bit  prev_we = 1'b0;

  bit m_active;
  int m_len[$];
  int m_cur;

  task automatic check(string name, int got, int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic void m_clear();
    m_len.delete();
    m_cur = 0;
  endfunction

  // pixel lands at row*160+col while inside the 160x144 window
  function automatic void m_pixel(int d);
    wr_t w;
    if (!m_active) return;
    if (m_len.size() < 144 && m_cur < 160) begin
      w.addr = m_len.size() * 160 + m_cur;
      w.data = 3 - d;
      exp_wr.push_back(w);
    end
    m_cur++;
  endfunction

  function automatic void m_line();
    if (m_active && m_cur > 0) begin
      m_len.push_back(m_cur);
      m_cur = 0;
    end
  endfunction

  function automatic void m_frame();
    int lines;
    bit ok;
    if (!m_active) begin
      m_active = 1'b1;
      m_clear();
      return;
    end
    lines = (m_len.size() > 144 ? 144 : m_len.size()) + (m_cur > 0 ? 1 : 0);
    ok = (lines == 144);
    foreach (m_len[i]) if (m_len[i] != 160) ok = 1'b0;
    if (m_cur > 0 && m_cur != 160) ok = 1'b0;
    exp_ok.push_back(ok);
    m_clear();
  endfunction

  always @(negedge clk) begin
    if (fb_we) begin
      check("we_not_back_to_back", int'(prev_we), 0);
      if (exp_wr.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %0d din %0d, none expected",
                 fb_waddr, fb_din);
      end else begin
        mon_w = exp_wr.pop_front();
        check("fb_waddr", int'(fb_waddr), mon_w.addr);
        check("fb_din", int'(fb_din), mon_w.data);
      end
    end
    prev_we = fb_we;
    if (frame_done) begin
      if (exp_ok.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_frame_done: frame_ok %0d, none expected",
                 frame_ok);
      end else begin
        mon_ok = exp_ok.pop_front();
        check("frame_ok", int'(frame_ok), int'(mon_ok));
      end
    end
  end

  task automatic pix(int d, int gap);
    @(negedge clk);
    gb_data = 2'(d);
    gb_pclk = 1'b0;
    m_pixel(d);
    @(negedge clk);
    gb_pclk = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // any mix of pixel, hsync and vsync edges in the same cycle
  task automatic ev(bit p, bit h, bit v, int d);
    @(negedge clk);
    if (p) begin
      gb_data = 2'(d);
      gb_pclk = 1'b0;
      m_pixel(d);
    end
    if (h) gb_hsync = 1'b1;
    if (v) gb_vsync = 1'b1;
    if (v) m_frame();
    else if (h) m_line();
    @(negedge clk);
    gb_pclk = 1'b1;
    @(negedge clk);
    gb_hsync = 1'b0;
    gb_vsync = 1'b0;
    @(negedge clk);
  endtask

  task automatic pixels(int n, int maxgap);
    for (int i = 0; i < n; i++)
      pix($urandom_range(0, 3), $urandom_range(0, maxgap));
  endtask

  task automatic line(int n, int maxgap);
    pixels(n, maxgap);
    ev(1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic check_idle(string tag);
    check({tag, "_fb_waddr"}, int'(fb_waddr), 0);
    check({tag, "_fb_din"}, int'(fb_din), 0);
    check({tag, "_fb_we"}, int'(fb_we), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_frame_ok"}, int'(frame_ok), 0);
    check({tag, "_capturing"}, int'(capturing), 0);
  endtask

  initial begin
    reset_n  = 1'b0;
    gb_pclk  = 1'b1;
    gb_hsync = 1'b0;
    gb_vsync = 1'b0;
    gb_data  = 2'b00;
    m_active = 1'b0;
    m_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("reset");

    // bus activity before the first vsync must be ignored
    pixels(10, 1);
    ev(1'b0, 1'b1, 1'b0, 0);
    ev(1'b1, 1'b1, 1'b0, 1);
    repeat (4) @(negedge clk);
    check("capturing_before_vsync", int'(capturing), 0);
    ev(1'b0, 1'b0, 1'b1, 0);
    @(negedge clk);
    check("capturing_after_vsync", int'(capturing), 1);

    // short lines, then a timed pixel at row 5, col 7
    for (int l = 0; l < 5; l++) line($urandom_range(1, 3), 2);
    pixels(7, 2);
    @(negedge clk);
    gb_data = 2'b01;
    gb_pclk = 1'b0;
    m_pixel(1);
    @(posedge clk);
    @(posedge clk);
    #1 check("latency_we_early", int'(fb_we), 0);
    @(posedge clk);
    #1 check("latency_we", int'(fb_we), 1);
    check("latency_addr", int'(fb_waddr), 807);
    check("latency_din", int'(fb_din), 2);
    @(negedge clk);
    gb_pclk = 1'b1;
    ev(1'b0, 1'b0, 1'b1, 0);

    // overlong line, then pixel coincident with the line latch
    line(165, 0);
    pixels(159, 0);
    ev(1'b1, 1'b1, 1'b0, $urandom_range(0, 3));
    pixels(5, 1);
    ev(1'b0, 1'b0, 1'b1, 0);

    // short frame closed by a pixel coincident with vsync
    line(160, 0);
    line(160, 0);
    pixels(159, 0);
    ev(1'b1, 1'b0, 1'b1, $urandom_range(0, 3));

    // exact 160x144 frame
    for (int l = 0; l < 144; l++) line(160, 0);
    ev(1'b0, 1'b0, 1'b1, 0);
    repeat (4) @(negedge clk);
    check("frame_ok_clean", int'(frame_ok), 1);

    // mid-line reset
    line(160, 0);
    pixels(70, 0);
    repeat (4) @(negedge clk);
    check("frame_ok_holds", int'(frame_ok), 1);
    reset_n = 1'b0;
    m_active = 1'b0;
    m_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("midreset");
    pixels(20, 1);
    ev(1'b0, 1'b1, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("capturing_after_reset", int'(capturing), 0);
    ev(1'b0, 1'b0, 1'b1, 0);

    // one full line closed by hsync and vsync together
    pixels(160, 0);
    ev(1'b0, 1'b1, 1'b1, 0);

    repeat (10) @(negedge clk);
    check("writes_outstanding", exp_wr.size(), 0);
    check("frames_outstanding", exp_ok.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
